// File: rtl/my_types_pkg.sv
// Shared pipeline control types.
// FSM state encoding and register-index type.
package my_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hold/flush/bubble sequencer with halt drain
// FSM and saturating stall/flush performance counters.
module pipeline_ctrl
  import my_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_taken,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_halt,
  input  logic             memwb_halt,
  output logic             WEN,
  output logic             ifid_WEN,
  output logic             ifid_FLUSH,
  output logic             idex_bubble,
  output logic             pc_WEN,
  output logic             pc_redirect,
  output logic             halted,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t r_state;
  pctrl_state_t w_next;

  logic w_act, w_dwait, w_lu, w_hold;
  logic w_r1, w_r2, w_r3, w_r4, w_r5, w_r6;

  assign w_act   = (r_state != HALTED);
  assign w_dwait = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign w_lu    = idex_dREN & (idex_rd != '0) &
                   ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
  assign w_hold  = (r_state == DRAIN) | ifid_halt;

  // One-hot row selects so the decoder below is truly unique.
  assign w_r1 = w_act & w_dwait;
  assign w_r2 = w_act & ~w_dwait & exmem_taken;
  assign w_r3 = w_act & ~w_dwait & ~exmem_taken & w_lu;
  assign w_r4 = w_act & ~w_dwait & ~exmem_taken & ~w_lu & w_hold;
  assign w_r5 = w_act & ~w_dwait & ~exmem_taken & ~w_lu & ~w_hold & ~ihit;
  assign w_r6 = w_act & ~w_dwait & ~exmem_taken & ~w_lu & ~w_hold & ihit;

  always_comb begin
    WEN         = 1'b0;
    ifid_WEN    = 1'b0;
    ifid_FLUSH  = 1'b0;
    idex_bubble = 1'b0;
    pc_WEN      = 1'b0;
    pc_redirect = 1'b0;
    w_next      = r_state;
    unique case (1'b1)
      w_r1: begin
      end
      w_r2: begin
        WEN         = 1'b1;
        ifid_FLUSH  = 1'b1;
        idex_bubble = 1'b1;
        pc_WEN      = 1'b1;
        pc_redirect = 1'b1;
        w_next      = RUN;
      end
      w_r3: begin
        WEN         = 1'b1;
        idex_bubble = 1'b1;
      end
      w_r4: begin
        WEN        = 1'b1;
        ifid_FLUSH = 1'b1;
        w_next     = DRAIN;
      end
      w_r5: begin
        WEN        = 1'b1;
        ifid_FLUSH = 1'b1;
      end
      w_r6: begin
        WEN      = 1'b1;
        ifid_WEN = 1'b1;
        pc_WEN   = 1'b1;
      end
      default: begin
      end
    endcase
    // A retiring halt beats any redirect of younger work.
    if (w_act && memwb_halt && !w_dwait) begin
      w_next = HALTED;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_next;
  end

  assign halted = (r_state == HALTED);

  sat_counter #(.W(CNT_W)) u_dstall (
    .clk(CLK), .rst(RST), .inc(w_r1), .clr(1'b0), .count(dstall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hazard (
    .clk(CLK), .rst(RST), .inc(w_r3), .clr(1'b0), .count(hazard_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk(CLK), .rst(RST), .inc(w_r2), .clr(1'b0), .count(flush_cnt)
  );

endmodule
